low_frequency_apb_regbank: RTL and testbench
============================================

# low_frequency_apb_regbank

APB completer register bank in the low-frequency `b_pclk` domain. It sits directly downstream of the bridge's B-side APB requester and consumes its `b_psel`/`b_penable`/`b_paddr`/`b_pwdata`/`b_pstrb`/`b_pprot`/`b_pwrite`. It returns `b_pready`/`b_prdata` to the bridge after a programmable number of wait states. It exposes `NUM_REGS` byte-strobed control registers plus one read-only status word to local logic.

## Interface
- `ADDR_WD`, 32, APB address width.
- `DATA_WD`, 32, APB data width; must equal 8*`STRB_WD`.
- `STRB_WD`, 4, byte-strobe width.
- `PROT_WD`, 3, protection width.
- `NUM_REGS`, 16, register count, power of two, ≥2; index `NUM_REGS-1` is the read-only status word.
- `WAIT_CYCLES`, 2, access-phase wait states before `b_pready` (0..15).

Ports:
- `b_pclk`  in  1  clock.
- `b_prst_n`  in  1  reset; b_prst_n, asynchronous, active-low; clock b_pclk.
- `b_psel`  in  1  APB select.
- `b_penable`  in  1  APB enable.
- `b_pwrite`  in  1  1 = write.
- `b_paddr`  in  `ADDR_WD`  byte address.
- `b_pwdata`  in  `DATA_WD`  write data.
- `b_pprot`  in  `PROT_WD`  protection; bit 0 = privileged.
- `b_pstrb`  in  `STRB_WD`  write byte strobes.
- `b_prdata`  out  `DATA_WD`  read data, valid while `b_pready`=1.
- `b_pready`  out  1  transfer complete.
- `b_pslverr`  out  1  error response, valid while `b_pready`=1.
- `status_in`  in  `DATA_WD`  value returned at index `NUM_REGS-1`.
- `reg_q`  out  `NUM_REGS*DATA_WD`  flattened register contents; slot i at `[i*DATA_WD +: DATA_WD]`; slot `NUM_REGS-1` is driven 0.
- `wr_pulse`  out  `NUM_REGS`  one-cycle pulse per register on a committed write.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE → ACCESS on setup (`b_psel`=1, `b_penable`=0).
  - Captures address, write, strobes, pprot, decode result.
  - Loads wait counter with `WAIT_CYCLES`.
- ACCESS: counter decrements while `b_psel`=1. When it reaches 0, registers `b_pready`=1 and enters RESP.
  - With `WAIT_CYCLES`=0, ACCESS lasts zero cycles: `b_pready` rises at the edge ending setup.
- RESP: `b_pready`=1 for exactly one cycle (`pfire` = `b_penable` & `b_pready`), then IDLE.
- Decode: index = `b_paddr[2 +: log2(NUM_REGS)]`.
  - Error if any higher address bit ≠ 0 or `b_paddr[1:0]` ≠ 0.
  - Error if a write targets index `NUM_REGS-1`.
  - Error if a write has `b_pprot[0]`=0 and targets index 0 (privileged control register).
- Write commit at the `pfire` edge, only if no error.
  - Each byte lane k updates only when `b_pstrb[k]`=1.
  - `wr_pulse[idx]`=1 for the following cycle.
  - All-zero `b_pstrb`: no change, no pulse, no error.
- Read: `b_prdata` is registered, loaded at the edge that raises `b_pready`.
  - Returns register contents, or `status_in` sampled at that edge for the last index.
  - Returns 0 on error.
  - `b_prdata` is 0 whenever `b_pready`=0.
- Error: `b_pslverr`=1 only together with `b_pready`; otherwise 0.
- Protocol violation: `b_psel` falling in ACCESS returns the FSM to IDLE. No pready, no write, no pulse.

## Timing
- Reset values: `b_pready`=0, `b_pslverr`=0, `b_prdata`=0, `wr_pulse`=0, all registers 0, FSM IDLE.
- Setup in cycle S → `b_pready` high in cycle S+1+`WAIT_CYCLES`. Write data is visible on `reg_q` from cycle S+2+`WAIT_CYCLES`.
- A new setup is accepted in the cycle immediately after RESP; there is no dead cycle.
- `b_pwdata`/`b_pstrb` are sampled at the `pfire` edge; `b_paddr`/`b_pwrite`/`b_pprot` at the setup edge.
- Reset asserted mid-transfer: immediate return to reset values. No partial write. `b_pready` stays 0 until a fresh setup.
- No combinational path from any input to `b_pready`, `b_prdata`, or `b_pslverr`.

## Test plan
- Write `0xDEADBEEF` to `0x04`, strobe `0xF`, `WAIT_CYCLES`=2 → `b_pready` at S+3, `b_pslverr`=0, `wr_pulse[1]` at S+4, slot 1 = `0xDEADBEEF`. Read `0x04` → `b_prdata`=`0xDEADBEEF`.
- Write `0x11223344` to `0x04` with strobe `0x5` over `0xDEADBEEF` → slot 1 = `0xDE22BE44`. Then write with strobe `0x0` → unchanged, no pulse.
- Errors, each → `b_pslverr`=1, no state change:
  - Read `0x40` (`NUM_REGS`=16) → `b_prdata`=0.
  - Access `0x06` (misaligned).
  - Write `0x3C` (status).
  - Write `0x00` with `b_pprot`=`3'b000`.
- Read `0x3C` with `status_in`=`0xA5A5_0001` → `b_prdata`=`0xA5A50001`, `b_pslverr`=0.
- `WAIT_CYCLES`=0, back-to-back write then read at `0x08` → `b_pready` in the first access cycle of each; the read returns the just-written value.
- Drop `b_psel` during ACCESS → no `b_pready`. Assert `b_prst_n`=0 mid-ACCESS of a write → all outputs and registers 0, and the next transfer completes normally.

Source files
------------

// File: rtl/low_frequency_apb_regbank_if.sv
// rtl/low_frequency_apb_regbank_if.sv - APB bus bundle between the bridge B-side requester and the register bank
interface low_frequency_apb_regbank_if #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 32,
    parameter int STRB_WD = 4,
    parameter int PROT_WD = 3
);
    logic               b_psel;
    logic               b_penable;
    logic               b_pwrite;
    logic [ADDR_WD-1:0] b_paddr;
    logic [DATA_WD-1:0] b_pwdata;
    logic [PROT_WD-1:0] b_pprot;
    logic [STRB_WD-1:0] b_pstrb;
    logic [DATA_WD-1:0] b_prdata;
    logic               b_pready;
    logic               b_pslverr;

    modport master (
        output b_psel, b_penable, b_pwrite, b_paddr, b_pwdata, b_pprot, b_pstrb,
        input  b_prdata, b_pready, b_pslverr
    );

    modport slave (
        input  b_psel, b_penable, b_pwrite, b_paddr, b_pwdata, b_pprot, b_pstrb,
        output b_prdata, b_pready, b_pslverr
    );
endinterface

// File: rtl/low_frequency_apb_regbank.sv
// rtl/low_frequency_apb_regbank.sv - APB completer with byte-strobed control registers and a read-only status word
module low_frequency_apb_regbank #(
    parameter int ADDR_WD     = 32,
    parameter int DATA_WD     = 32,
    parameter int STRB_WD     = 4,
    parameter int PROT_WD     = 3,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                         b_pclk,
    input  logic                         b_prst_n,
    low_frequency_apb_regbank_if.slave   apb,
    input  logic [DATA_WD-1:0]           status_in,
    output logic [NUM_REGS*DATA_WD-1:0]  reg_q,
    output logic [NUM_REGS-1:0]          wr_pulse
);
    localparam int                IDX_WD    = $clog2(NUM_REGS);
    localparam logic [IDX_WD-1:0] LAST_IDX  = IDX_WD'(NUM_REGS - 1);
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_WD-1:0]  prdata_q, prdata_d;
    logic [IDX_WD-1:0]   idx_q;
    logic                write_q;
    logic                err_q;
    logic [DATA_WD-1:0]  regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q;

    logic                capture;
    logic                commit;
    logic                pfire;
    logic [IDX_WD-1:0]   dec_idx;
    logic                dec_err;
    logic [IDX_WD-1:0]   sel_idx;
    logic                sel_err;
    logic                sel_write;
    logic [DATA_WD-1:0]  rd_word;
    logic                unused_prot;

    assign unused_prot = ^apb.b_pprot;

    // Decode is evaluated on the live bus and frozen at the setup edge.
    assign dec_idx = apb.b_paddr[2 +: IDX_WD];
    assign dec_err = (|(apb.b_paddr >> (2 + IDX_WD)))
                   | (|apb.b_paddr[1:0])
                   | (apb.b_pwrite & (dec_idx == LAST_IDX))
                   | (apb.b_pwrite & ~apb.b_pprot[0] & (dec_idx == '0));

    // With zero wait states the response is loaded at the setup edge, so use the live decode.
    assign sel_idx   = (state_q == S_IDLE) ? dec_idx      : idx_q;
    assign sel_err   = (state_q == S_IDLE) ? dec_err      : err_q;
    assign sel_write = (state_q == S_IDLE) ? apb.b_pwrite : write_q;
    assign rd_word   = (sel_idx == LAST_IDX) ? status_in : regs_q[sel_idx];

    assign pfire = apb.b_penable & pready_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        capture   = 1'b0;
        commit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (apb.b_psel && !apb.b_penable) begin
                    capture = 1'b1;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_INIT == 4'd0) begin
                        state_d   = S_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = sel_err;
                        prdata_d  = (sel_err || sel_write) ? '0 : rd_word;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (!apb.b_psel) begin
                    state_d = S_IDLE;
                end else if (cnt_q <= 4'd1) begin
                    cnt_d     = 4'd0;
                    state_d   = S_RESP;
                    pready_d  = 1'b1;
                    pslverr_d = sel_err;
                    prdata_d  = (sel_err || sel_write) ? '0 : rd_word;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                commit  = pfire & write_q & ~err_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge b_pclk or negedge b_prst_n) begin
        if (!b_prst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    always_ff @(posedge b_pclk or negedge b_prst_n) begin
        if (!b_prst_n) begin
            idx_q      <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            regs_q     <= '{default: '0};
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (capture) begin
                idx_q   <= dec_idx;
                write_q <= apb.b_pwrite;
                err_q   <= dec_err;
            end
            if (commit) begin
                for (int k = 0; k < STRB_WD; k++) begin
                    if (apb.b_pstrb[k]) begin
                        regs_q[idx_q][k*8 +: 8] <= apb.b_pwdata[k*8 +: 8];
                    end
                end
                if (|apb.b_pstrb) begin
                    wr_pulse_q[idx_q] <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        if (i == NUM_REGS - 1) begin : g_status
            assign reg_q[i*DATA_WD +: DATA_WD] = '0;
        end else begin : g_ctrl
            assign reg_q[i*DATA_WD +: DATA_WD] = regs_q[i];
        end
    end

    assign wr_pulse      = wr_pulse_q;
    assign apb.b_pready  = pready_q;
    assign apb.b_pslverr = pslverr_q;
    assign apb.b_prdata  = prdata_q;
endmodule

// File: tb/tb_low_frequency_apb_regbank.sv
// tb/tb_low_frequency_apb_regbank.sv - directed scoreboard bench for two wait-state configurations
module tb_low_frequency_apb_regbank;
    typedef struct packed {
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         dsel = 1'b0;
    logic         psel = 1'b0;
    logic         penable = 1'b0;
    logic         pwrite = 1'b0;
    logic [31:0]  paddr = '0;
    logic [31:0]  pwdata = '0;
    logic [3:0]   pstrb = '0;
    logic [2:0]   pprot = 3'b001;
    logic [31:0]  status = '0;
    logic [511:0] rq2, rq0;
    logic [15:0]  wp2, wp0;
    logic [31:0]  mdl [2][16];
    exp_t         sb_q [$];
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    low_frequency_apb_regbank_if #(.ADDR_WD(32), .DATA_WD(32), .STRB_WD(4), .PROT_WD(3)) if2 ();
    low_frequency_apb_regbank_if #(.ADDR_WD(32), .DATA_WD(32), .STRB_WD(4), .PROT_WD(3)) if0 ();

    assign if2.b_psel    = psel & ~dsel;
    assign if0.b_psel    = psel & dsel;
    assign if2.b_penable = penable;
    assign if0.b_penable = penable;
    assign if2.b_pwrite  = pwrite;
    assign if0.b_pwrite  = pwrite;
    assign if2.b_paddr   = paddr;
    assign if0.b_paddr   = paddr;
    assign if2.b_pwdata  = pwdata;
    assign if0.b_pwdata  = pwdata;
    assign if2.b_pstrb   = pstrb;
    assign if0.b_pstrb   = pstrb;
    assign if2.b_pprot   = pprot;
    assign if0.b_pprot   = pprot;

    low_frequency_apb_regbank #(.NUM_REGS(16), .WAIT_CYCLES(2)) u_dut2 (
        .b_pclk(clk), .b_prst_n(rst_n), .apb(if2.slave),
        .status_in(status), .reg_q(rq2), .wr_pulse(wp2)
    );

    low_frequency_apb_regbank #(.NUM_REGS(16), .WAIT_CYCLES(0)) u_dut0 (
        .b_pclk(clk), .b_prst_n(rst_n), .apb(if0.slave),
        .status_in(status), .reg_q(rq0), .wr_pulse(wp0)
    );

    logic        pready_m, pslverr_m;
    logic [31:0] prdata_m;
    logic [15:0] pulse_m;
    assign pready_m  = dsel ? if0.b_pready  : if2.b_pready;
    assign pslverr_m = dsel ? if0.b_pslverr : if2.b_pslverr;
    assign prdata_m  = dsel ? if0.b_prdata  : if2.b_prdata;
    assign pulse_m   = dsel ? wp0 : wp2;

    function automatic logic [31:0] slot(input int i);
        return dsel ? rq0[i*32 +: 32] : rq2[i*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts right after a rising edge; returns right after the edge following the response.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot);
        int          idx, n, lat;
        logic        err;
        logic [15:0] exp_pulse;
        logic [31:0] v;
        exp_t        e, got;
        idx = int'(addr[5:2]);
        err = (addr[31:6] != 0) || (addr[1:0] != 0) || (wr && idx == 15) || (wr && !prot[0] && idx == 0);
        e.err = err;
        e.rd  = (err || wr) ? 32'h0 : ((idx == 15) ? status : mdl[dsel][idx]);
        sb_q.push_back(e);
        lat = dsel ? 1 : 3;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = wdata; pstrb = strb; pprot = prot;
        @(posedge clk); #1 penable = 1'b1;
        n = 1;
        @(negedge clk);
        while (pready_m !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, lat);
        got = sb_q.pop_front();
        chk("pslverr", {31'b0, pslverr_m}, {31'b0, got.err});
        chk("prdata", prdata_m, got.rd);
        exp_pulse = '0;
        if (wr && !err && strb != 4'h0) begin
            v = mdl[dsel][idx];
            for (int k = 0; k < 4; k++) if (strb[k]) v[k*8 +: 8] = wdata[k*8 +: 8];
            mdl[dsel][idx] = v;
            exp_pulse[idx] = 1'b1;
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        chk("pready_one_cycle", {31'b0, pready_m}, 32'h0);
        chk("prdata_idle", prdata_m, 32'h0);
        chk("wr_pulse", {16'b0, pulse_m}, {16'b0, exp_pulse});
        chk("slot", slot(idx), mdl[dsel][idx]);
    endtask

    initial begin
        logic seen_rdy, seen_pulse;
        for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) mdl[d][i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pready2", {31'b0, if2.b_pready}, 32'h0);
        chk("rst_pslverr2", {31'b0, if2.b_pslverr}, 32'h0);
        chk("rst_prdata2", if2.b_prdata, 32'h0);
        chk("rst_pready0", {31'b0, if0.b_pready}, 32'h0);
        chk("rst_pulse", {16'b0, wp2 | wp0}, 32'h0);
        for (int i = 0; i < 16; i++) chk("rst_slot", rq2[i*32 +: 32] | rq0[i*32 +: 32], 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        dsel = 1'b0;
        xfer(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b001);
        chk("slot1_full", slot(1), 32'hDEADBEEF);
        xfer(1'b0, 32'h04, 32'h0, 4'h0, 3'b001);
        xfer(1'b1, 32'h04, 32'h11223344, 4'h5, 3'b001);
        chk("slot1_strobed", slot(1), 32'hDE22BE44);
        xfer(1'b1, 32'h04, 32'hFFFFFFFF, 4'h0, 3'b001);
        chk("slot1_nostrb", slot(1), 32'hDE22BE44);
        xfer(1'b0, 32'h40, 32'h0, 4'h0, 3'b001);
        xfer(1'b0, 32'h06, 32'h0, 4'h0, 3'b001);
        xfer(1'b1, 32'h06, 32'h55555555, 4'hF, 3'b001);
        xfer(1'b1, 32'h3C, 32'h12345678, 4'hF, 3'b001);
        xfer(1'b1, 32'h00, 32'h0BADF00D, 4'hF, 3'b000);
        chk("slot0_protected", slot(0), 32'h0);
        xfer(1'b1, 32'h00, 32'h600DCAFE, 4'hF, 3'b001);
        xfer(1'b0, 32'h00, 32'h0, 4'h0, 3'b000);
        status = 32'hA5A5_0001;
        xfer(1'b0, 32'h3C, 32'h0, 4'h0, 3'b001);

        dsel = 1'b1;
        xfer(1'b1, 32'h08, 32'hCAFEF00D, 4'hF, 3'b001);
        xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b001);
        xfer(1'b0, 32'h3C, 32'h0, 4'h0, 3'b001);

        dsel = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08;
        pwdata = 32'h55AA55AA; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        seen_rdy = 1'b0; seen_pulse = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen_rdy   = seen_rdy | pready_m;
            seen_pulse = seen_pulse | (|pulse_m);
        end
        chk("drop_pready", {31'b0, seen_rdy}, 32'h0);
        chk("drop_pulse", {31'b0, seen_pulse}, 32'h0);
        chk("drop_slot", slot(2), mdl[0][2]);
        @(posedge clk); #1;

        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
        pwdata = 32'h12345678; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("rstmid_pready", {31'b0, if2.b_pready}, 32'h0);
        chk("rstmid_pslverr", {31'b0, if2.b_pslverr}, 32'h0);
        chk("rstmid_prdata", if2.b_prdata, 32'h0);
        chk("rstmid_pulse", {16'b0, wp2 | wp0}, 32'h0);
        for (int i = 0; i < 16; i++) chk("rstmid_slot", rq2[i*32 +: 32] | rq0[i*32 +: 32], 32'h0);
        for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) mdl[d][i] = '0;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_pready", {31'b0, if2.b_pready}, 32'h0);
        xfer(1'b1, 32'h10, 32'h87654321, 4'hF, 3'b001);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b001);

        chk("sb_empty", sb_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
